// File: rtl/fpu_pkg.sv
// FPU op codes and issue-stage FSM states.
// Shared by the FPU, its issue controller and their benches.
package fpu_pkg;
   localparam int CTL_W = 5;

   localparam logic [CTL_W-1:0] FADD    = 5'd0;
   localparam logic [CTL_W-1:0] FSUB    = 5'd1;
   localparam logic [CTL_W-1:0] FMUL    = 5'd2;
   localparam logic [CTL_W-1:0] FINV    = 5'd3;
   localparam logic [CTL_W-1:0] FDIV    = 5'd4;
   localparam logic [CTL_W-1:0] FHALF   = 5'd5;
   localparam logic [CTL_W-1:0] FTOI    = 5'd6;
   localparam logic [CTL_W-1:0] ITOF    = 5'd7;
   localparam logic [CTL_W-1:0] FLOOR   = 5'd8;
   localparam logic [CTL_W-1:0] FEQ     = 5'd9;
   localparam logic [CTL_W-1:0] FLE     = 5'd10;
   localparam logic [CTL_W-1:0] FABS    = 5'd11;
   localparam logic [CTL_W-1:0] FNEG    = 5'd12;
   localparam logic [CTL_W-1:0] FLESS   = 5'd13;
   localparam logic [CTL_W-1:0] FMIN    = 5'd14;
   localparam logic [CTL_W-1:0] FMAX    = 5'd15;
   localparam logic [CTL_W-1:0] FISZERO = 5'd16;
   localparam logic [CTL_W-1:0] FISPOS  = 5'd17;
   localparam logic [CTL_W-1:0] FISNEG  = 5'd18;
   localparam logic [CTL_W-1:0] FSQRT   = 5'd19;
   localparam logic [CTL_W-1:0] FSQR    = 5'd20;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } fsm_state_e;
endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Core-side request channel and writeback channel of the FPU issue stage.
// master = core, slave = issue controller.
interface fpu_issue_ctrl_if
   import fpu_pkg::*;
#(
   parameter int TAG_W = 6
) ();
   logic             req_valid;
   logic             req_ready;
   logic [CTL_W-1:0] req_ctl;
   logic [31:0]      req_x1;
   logic [31:0]      req_x2;
   logic [TAG_W-1:0] req_tag;
   logic             wb_valid;
   logic             wb_ready;
   logic [31:0]      wb_data;
   logic [TAG_W-1:0] wb_tag;

   modport master (
      output req_valid, req_ctl, req_x1, req_x2, req_tag, wb_ready,
      input  req_ready, wb_valid, wb_data, wb_tag
   );

   modport slave (
      input  req_valid, req_ctl, req_x1, req_x2, req_tag, wb_ready,
      output req_ready, wb_valid, wb_data, wb_tag
   );
endinterface

// File: rtl/fpu_req_fifo.sv
// Small synchronous FIFO with occupancy count; head is read combinationally.
module fpu_req_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      do_push = push && (count_q != CW'(DEPTH));
      do_pop  = pop && (count_q != '0);
      wptr_d  = wptr_q + AW'(do_push);
      rptr_d  = rptr_q + AW'(do_pop);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: pointers alone define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

   assign rdata = mem_q[rptr_q];
   assign count = count_q;
endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue stage in front of the FPU: request FIFO, single-outstanding
// en/ready sequencing with watchdog, and a one-entry writeback register.
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 6,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rstn,
   fpu_issue_ctrl_if.slave  io,
   output logic [CTL_W-1:0] fpu_ctl,
   output logic [31:0]      fpu_x1,
   output logic [31:0]      fpu_x2,
   output logic             fpu_en,
   input  logic [31:0]      fpu_y,
   input  logic             fpu_ready,
   output logic             busy,
   output logic             timeout_err
);
   localparam int EW = CTL_W + 64 + TAG_W;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);

   fsm_state_e       state_q, state_d;
   logic             en_q, en_d;
   logic [CTL_W-1:0] ctl_q, ctl_d;
   logic [31:0]      x1_q, x1_d;
   logic [31:0]      x2_q, x2_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [WW-1:0]    wd_q, wd_d;
   logic             wbv_q, wbv_d;
   logic [31:0]      wbd_q, wbd_d;
   logic [TAG_W-1:0] wbt_q, wbt_d;
   logic             err_q, err_d;

   logic [CW-1:0]    count;
   logic [EW-1:0]    head;
   logic             req_ready;
   logic             push, pop;

   // Ready looks only at the registered count, never at this cycle's pop.
   assign req_ready = (count != CW'(DEPTH));
   assign push      = io.req_valid && req_ready;

   fpu_req_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .wdata ({io.req_ctl, io.req_x1, io.req_x2, io.req_tag}),
      .pop   (pop),
      .rdata (head),
      .count (count)
   );

   always_comb begin
      state_d = state_q;
      en_d    = 1'b0;
      ctl_d   = ctl_q;
      x1_d    = x1_q;
      x2_d    = x2_q;
      tag_d   = tag_q;
      wd_d    = wd_q;
      wbv_d   = wbv_q && !io.wb_ready;
      wbd_d   = wbd_q;
      wbt_d   = wbt_q;
      err_d   = err_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // Only issue when the wb slot is free by the time the result lands.
            if (count != '0 && (!wbv_q || io.wb_ready)) begin
               pop     = 1'b1;
               state_d = S_ISSUE;
               en_d    = 1'b1;
               wd_d    = '0;
               {ctl_d, x1_d, x2_d, tag_d} = head;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (fpu_ready) begin
               wbv_d   = 1'b1;
               wbd_d   = fpu_y;
               wbt_d   = tag_q;
               state_d = S_IDLE;
            end else begin
               wd_d = wd_q + WW'(1);
               if (wd_d == WD_MAX) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         en_q    <= 1'b0;
         ctl_q   <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         tag_q   <= '0;
         wd_q    <= '0;
         wbv_q   <= 1'b0;
         wbd_q   <= '0;
         wbt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         ctl_q   <= ctl_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         tag_q   <= tag_d;
         wd_q    <= wd_d;
         wbv_q   <= wbv_d;
         wbd_q   <= wbd_d;
         wbt_q   <= wbt_d;
         err_q   <= err_d;
      end
   end

   assign io.req_ready = req_ready;
   assign io.wb_valid  = wbv_q;
   assign io.wb_data   = wbd_q;
   assign io.wb_tag    = wbt_q;
   assign fpu_en       = en_q;
   assign fpu_ctl      = ctl_q;
   assign fpu_x1       = x1_q;
   assign fpu_x2       = x2_q;
   assign timeout_err  = err_q;
   assign busy         = (state_q != S_IDLE) || (count != '0) || wbv_q;
endmodule
